// File: rtl/transmissao_serial_pkg.sv
// Shared definitions for the serial-transmission block: FSM state encoding,
// default timeout and pixel-RAM geometry used by control unit and datapath.
package transmissao_serial_pkg;

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      ZERA         = 4'd1,
      CARREGA      = 4'd2,
      ENVIA        = 4'd3,
      ESPERA       = 4'd4,
      PROX_BYTE    = 4'd5,
      TESTA_COLUNA = 4'd6,
      INC_COLUNA   = 4'd7,
      TESTA_LINHA  = 4'd8,
      INC_LINHA    = 4'd9,
      FIM          = 4'd10,
      ERRO         = 4'd11
   } estado_t;

   // Cycles allowed in ESPERA before the UART is considered stuck.
   localparam int TIMEOUT_PADRAO = 100000;

   // Pixel RAM is LINES x COLUMNS, 16-bit pixels sent as two bytes.
   localparam int LINES   = 3;
   localparam int COLUMNS = 3;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the last count.
module contador_m #(
   parameter int M = 100000,
   parameter int N = 17
) (
   input  logic clock,
   input  logic reset,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);

   localparam logic [N-1:0] ULTIMO = N'(M - 1);

   logic [N-1:0] q;

   // Count while enabled, wrap after the last value, clear on zera_s.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (zera_s) begin
         q <= '0;
      end else if (conta) begin
         if (q == ULTIMO) q <= '0;
         else             q <= q + 1'b1;
      end
   end

   assign fim = (q == ULTIMO);

endmodule

// File: rtl/transmissao_serial_uc.sv
// Control unit for the serial-transmission datapath: walks the 3x3 pixel RAM
// row-major and sends each 16-bit pixel as two UART bytes (high, then low),
// aborting to ERRO if the UART never reports done.
module transmissao_serial_uc
   import transmissao_serial_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_PADRAO,
   parameter int TW      = 17
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       fim_coluna,
   input  logic       fim_linha,
   input  logic       pronto_serial,
   output logic       partida_serial,
   output logic       flipa,
   output logic       conta_linha,
   output logic       conta_coluna,
   output logic       zera_linha,
   output logic       zera_coluna,
   output logic       zera_shift,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   estado_t estado;
   logic    meio;        // 0: high byte in flight, 1: low byte in flight
   logic    fim_timeout;

   // Timeout counter: cleared when a byte is launched, runs while waiting.
   contador_m #(
      .M (TIMEOUT),
      .N (TW)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .zera_s (estado == ENVIA),
      .conta  (estado == ESPERA),
      .fim    (fim_timeout)
   );

   // State sequencing and byte-half tracking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= INICIAL;
         meio   <= 1'b0;
      end else begin
         case (estado)
            INICIAL:      if (iniciar) estado <= ZERA;
            ZERA: begin
               meio   <= 1'b0;
               estado <= CARREGA;
            end
            CARREGA:      estado <= ENVIA;
            ENVIA:        estado <= ESPERA;
            ESPERA: begin
               // A done pulse wins over a simultaneous timeout.
               if (pronto_serial)    estado <= PROX_BYTE;
               else if (fim_timeout) estado <= ERRO;
            end
            PROX_BYTE: begin
               if (!meio) begin
                  meio   <= 1'b1;
                  estado <= ENVIA;
               end else begin
                  meio   <= 1'b0;
                  estado <= TESTA_COLUNA;
               end
            end
            TESTA_COLUNA: estado <= fim_coluna ? TESTA_LINHA : INC_COLUNA;
            INC_COLUNA:   estado <= CARREGA;
            TESTA_LINHA:  estado <= fim_linha ? FIM : INC_LINHA;
            INC_LINHA:    estado <= CARREGA;
            FIM:          estado <= INICIAL;
            ERRO:         if (iniciar) estado <= ZERA;
            default:      estado <= INICIAL;
         endcase
      end
   end

   // Moore outputs decoded from the state register.
   assign partida_serial = (estado == ENVIA);
   assign flipa          = (estado == PROX_BYTE);
   assign conta_linha    = (estado == INC_LINHA);
   assign conta_coluna   = (estado == INC_COLUNA);
   assign zera_linha     = (estado == ZERA);
   assign zera_coluna    = (estado == ZERA) || (estado == INC_LINHA);
   assign zera_shift     = (estado == ZERA);
   assign pronto         = (estado == FIM);
   assign erro           = (estado == ERRO);
   assign db_estado      = estado;

endmodule

// File: tb/tb_transmissao_serial_uc.sv
// Bench for transmissao_serial_uc: models the datapath counters and a UART
// responder, and scoreboards the (row, column, byte) order of every launch.
module tb_transmissao_serial_uc;
   import transmissao_serial_pkg::*;

   localparam int TO = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic iniciar_main   = 1'b0;
   logic iniciar_glitch = 1'b0;
   logic iniciar;
   logic pronto_serial  = 1'b0;
   logic fim_coluna, fim_linha;
   logic partida_serial, flipa, conta_linha, conta_coluna;
   logic zera_linha, zera_coluna, zera_shift, pronto, erro;
   logic [3:0] db_estado;
   logic [8:0] outs;

   assign iniciar = iniciar_main | iniciar_glitch;
   assign outs = {partida_serial, flipa, conta_linha, conta_coluna,
                  zera_linha, zera_coluna, zera_shift, pronto, erro};

   transmissao_serial_uc #(.TIMEOUT(TO), .TW(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .iniciar        (iniciar),
      .fim_coluna     (fim_coluna),
      .fim_linha      (fim_linha),
      .pronto_serial  (pronto_serial),
      .partida_serial (partida_serial),
      .flipa          (flipa),
      .conta_linha    (conta_linha),
      .conta_coluna   (conta_coluna),
      .zera_linha     (zera_linha),
      .zera_coluna    (zera_coluna),
      .zera_shift     (zera_shift),
      .pronto         (pronto),
      .erro           (erro),
      .db_estado      (db_estado)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [4:0] exp_q[$];   // {row[1:0], col[1:0], low_byte}

   int row_m = 0, col_m = 0, sel_m = 0;
   int n_partida = 0, n_flipa = 0, n_cc = 0, n_cl = 0, n_pronto = 0, n_erro = 0;
   int s_partida, s_flipa, s_cc, s_cl, s_pronto, s_erro;

   // UART responder controls
   logic resp_en    = 1'b1;
   logic rand_delay = 1'b0;
   logic glitch_en  = 1'b0;
   int   fixed_delay = 5;
   int   resp_cnt    = 0;

   assign fim_coluna = (col_m == COLUMNS - 1);
   assign fim_linha  = (row_m == LINES - 1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // ---------------- monitor + datapath model ----------------
   always @(negedge clock) begin
      if (partida_serial) begin
         n_partida++;
         if (exp_q.size() == 0) begin
            check("partida_extra", 1, 0);
         end else begin
            check("partida_order", 32'({row_m[1:0], col_m[1:0], sel_m[0]}), 32'(exp_q.pop_front()));
         end
      end
      if (flipa)        n_flipa++;
      if (conta_coluna) n_cc++;
      if (conta_linha)  n_cl++;
      if (pronto)       n_pronto++;
      if (erro)         n_erro++;
      if (zera_linha)   row_m = 0;
      if (conta_linha)  row_m = row_m + 1;
      if (zera_coluna)  col_m = 0;
      if (conta_coluna) col_m = col_m + 1;
      if (zera_shift)   sel_m = 0;
      if (flipa)        sel_m = sel_m ^ 1;
   end

   // ---------------- UART responder / glitch injector ----------------
   always @(negedge clock) begin
      pronto_serial  = 1'b0;
      iniciar_glitch = 1'b0;
      if (!reset) begin
         resp_cnt = 0;
      end else begin
         if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) pronto_serial = 1'b1;
         end
         if (partida_serial && resp_en)
            resp_cnt = rand_delay ? int'($urandom_range(1, 7)) : fixed_delay;
         if (glitch_en) begin
            if (resp_cnt == 0 && (db_estado == 4'd2 || db_estado == 4'd6 || db_estado == 4'd8))
               pronto_serial = pronto_serial | 1'($urandom_range(0, 1));
            if (db_estado >= 4'd2 && db_estado <= 4'd9 && db_estado != 4'd4)
               iniciar_glitch = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_frame();
      for (int r = 0; r < LINES; r++)
         for (int c = 0; c < COLUMNS; c++)
            for (int b = 0; b < 2; b++)
               exp_q.push_back(5'((r << 3) | (c << 1) | b));
   endtask

   task automatic snap();
      s_partida = n_partida; s_flipa = n_flipa; s_cc = n_cc;
      s_cl = n_cl; s_pronto = n_pronto; s_erro = n_erro;
   endtask

   task automatic start_frame();
      push_frame();
      iniciar_main = 1'b1;
      @(negedge clock);
      iniciar_main = 1'b0;
      snap();
   endtask

   task automatic finish_frame(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (pronto) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_pronto_seen"}, 32'(seen), 1);
      @(negedge clock);
      check({tag, "_pronto_width"}, 32'(pronto), 0);
      check({tag, "_back_inicial"}, 32'(db_estado), 0);
      check({tag, "_partidas"}, 32'(n_partida - s_partida), 18);
      check({tag, "_flipas"}, 32'(n_flipa - s_flipa), 18);
      check({tag, "_conta_coluna"}, 32'(n_cc - s_cc), 6);
      check({tag, "_conta_linha"}, 32'(n_cl - s_cl), 2);
      check({tag, "_pronto_count"}, 32'(n_pronto - s_pronto), 1);
      check({tag, "_no_erro"}, 32'(n_erro - s_erro), 0);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic ok;

      // Reset held with iniciar high: everything idle.
      iniciar_main = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_estado", 32'(db_estado), 0);
      check("rst_outs", 32'(outs), 0);

      // Release: ZERA on the first edge, clears for one cycle.
      push_frame();
      reset = 1'b1;
      @(negedge clock);
      iniciar_main = 1'b0;
      snap();
      check("zera_estado", 32'(db_estado), 1);
      check("zera_clears", 32'({zera_linha, zera_coluna, zera_shift}), 7);
      @(negedge clock);
      check("carrega_estado", 32'(db_estado), 2);
      check("carrega_clears_off", 32'({zera_linha, zera_coluna, zera_shift}), 0);
      finish_frame("frame_d5");

      // Randomised UART latency.
      rand_delay = 1'b1;
      start_frame();
      finish_frame("frame_rand");

      // Fastest UART: done one cycle into ESPERA.
      rand_delay = 1'b0;
      fixed_delay = 1;
      start_frame();
      finish_frame("frame_d1");

      // Done arrives in the same cycle the timeout expires.
      fixed_delay = TO;
      start_frame();
      finish_frame("frame_boundary");

      // Stuck UART: ERRO exactly TO cycles after entering ESPERA.
      resp_en = 1'b0;
      start_frame();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (db_estado == 4'd4) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("timeout_reach_espera", 32'(ok), 1);
      ok = 1'b1;
      for (int k = 1; k < TO; k++) begin
         @(negedge clock);
         if (db_estado != 4'd4) ok = 1'b0;
      end
      check("timeout_hold_espera", 32'(ok), 1);
      @(negedge clock);
      check("timeout_estado", 32'(db_estado), 11);
      check("timeout_erro", 32'(erro), 1);
      exp_q.delete();
      repeat (3) @(negedge clock);
      check("erro_sticky", 32'({erro, db_estado}), 32'({1'b1, 4'd11}));
      resp_en = 1'b1;
      fixed_delay = 5;
      start_frame();
      finish_frame("frame_retry");

      // Spurious iniciar / pronto_serial mid-frame.
      rand_delay = 1'b1;
      glitch_en  = 1'b1;
      start_frame();
      finish_frame("frame_glitch");
      glitch_en  = 1'b0;
      rand_delay = 1'b0;

      // Reset during the 9th byte's ESPERA aborts with no pronto.
      start_frame();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         if (n_partida - s_partida >= 9 && db_estado == 4'd4) begin
            ok = 1'b1;
            break;
         end
      end
      check("abort_reach_byte9", 32'(ok), 1);
      #2 reset = 1'b0;
      #1;
      check("abort_async_estado", 32'(db_estado), 0);
      check("abort_async_outs", 32'(outs), 0);
      repeat (3) @(negedge clock);
      check("abort_no_pronto", 32'(n_pronto - s_pronto), 0);
      check("abort_partidas", 32'(n_partida - s_partida), 9);
      exp_q.delete();
      reset = 1'b1;
      @(negedge clock);
      start_frame();
      finish_frame("frame_after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
